victim_sel_plru: RTL and testbench

- Parametrised N-way victim selector for the set-associative caches in the io/cache hierarchy.
- Holds per-set tree pseudo-LRU state and updates it on every hit or fill touch.
- On request, returns a registered victim way for the indexed set. Priority order: invalid way, then optionally a clean way, then the PLRU choice.
- Sits between the cache controller FSM and the tag/data arrays, replacing the fixed 2-way selector.

---
 rtl/victim_sel_plru.sv | 123 ++++++++++++
 tb/tb_victim_sel_plru.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/victim_sel_plru.sv
// Per-set tree pseudo-LRU victim selector for N-way set-associative caches.
// Victim priority: lowest invalid way, then (optionally) lowest clean way, then the PLRU way.
module victim_sel_plru #(
  parameter int NUM_WAYS    = 4,
  parameter int NUM_SETS    = 64,
  parameter int DIRTY_AWARE = 1,
  localparam int WAY_W      = $clog2(NUM_WAYS),
  localparam int SET_W      = $clog2(NUM_SETS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                sel_req,
  input  logic [SET_W-1:0]    sel_set,
  input  logic [NUM_WAYS-1:0] line_valid,
  input  logic [NUM_WAYS-1:0] line_dirty,
  input  logic                touch_en,
  input  logic [SET_W-1:0]    touch_set,
  input  logic [WAY_W-1:0]    touch_way,
  output logic                sel_ack,
  output logic [WAY_W-1:0]    victim,
  output logic                victim_dirty
);

  localparam int NODES = NUM_WAYS - 1;

  logic [NODES-1:0]    tree_reg [NUM_SETS];
  logic [NODES-1:0]    sel_row;
  logic [NODES-1:0]    touch_cur;
  logic [NODES-1:0]    touch_next;
  logic [NUM_WAYS-1:0] plru_hot;
  logic [WAY_W-1:0]    plru_way;
  logic [WAY_W-1:0]    inv_way;
  logic [WAY_W-1:0]    clean_way;
  logic [WAY_W-1:0]    victim_next;
  logic                victim_dirty_next;
  logic                sel_ack_reg;
  logic [WAY_W-1:0]    victim_reg;
  logic                victim_dirty_reg;
  logic                accept;
  logic                touch;

  assign accept    = en & sel_req;
  assign touch     = en & touch_en;
  assign sel_row   = tree_reg[sel_set];
  assign touch_cur = tree_reg[touch_set];

  // Node gi sits at level LVL, position POS; it is on the touch path when the
  // top LVL bits of touch_way equal POS, and then points to the sibling subtree.
  for (genvar gi = 0; gi < NODES; gi++) begin : g_touch
    localparam int LVL = $clog2(gi + 2) - 1;
    localparam int POS = gi - (2 ** LVL - 1);
    logic on_path;
    if (LVL == 0) begin : g_root
      assign on_path = 1'b1;
    end else begin : g_inner
      assign on_path = (touch_way[WAY_W-1 -: LVL] == LVL'(POS));
    end
    assign touch_next[gi] = on_path ? ~touch_way[WAY_W-1-LVL] : touch_cur[gi];
  end

  // Way gi is the PLRU way when every node on its path points toward it.
  for (genvar gi = 0; gi < NUM_WAYS; gi++) begin : g_plru
    logic [WAY_W-1:0] lvl_ok;
    for (genvar gl = 0; gl < WAY_W; gl++) begin : g_lvl
      localparam int NODE = (2 ** gl) - 1 + (gi >> (WAY_W - gl));
      localparam int DIR  = (gi >> (WAY_W - 1 - gl)) & 1;
      assign lvl_ok[gl] = (sel_row[NODE] == 1'(DIR));
    end
    assign plru_hot[gi] = &lvl_ok;
  end

  always_comb begin
    plru_way  = '0;
    inv_way   = '0;
    clean_way = '0;
    for (int i = NUM_WAYS - 1; i >= 0; i--) begin
      if (plru_hot[i])
        plru_way = WAY_W'(i);
      if (!line_valid[i])
        inv_way = WAY_W'(i);
      if (!line_dirty[i])
        clean_way = WAY_W'(i);
    end
  end

  always_comb begin
    victim_next = plru_way;
    if (!(&line_valid))
      victim_next = inv_way;
    else if ((DIRTY_AWARE != 0) && line_dirty[plru_way] && !(&line_dirty))
      victim_next = clean_way;
    victim_dirty_next = line_dirty[victim_next];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < NUM_SETS; s++)
        tree_reg[s] <= '0;
    end else if (touch) begin
      tree_reg[touch_set] <= touch_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_ack_reg      <= 1'b0;
      victim_reg       <= '0;
      victim_dirty_reg <= 1'b0;
    end else begin
      sel_ack_reg <= accept;
      if (accept) begin
        victim_reg       <= victim_next;
        victim_dirty_reg <= victim_dirty_next;
      end
    end
  end

  assign sel_ack      = sel_ack_reg;
  assign victim       = victim_reg;
  assign victim_dirty = victim_dirty_reg;

endmodule

// File: tb/tb_victim_sel_plru.sv
// Bench for victim_sel_plru: directed scenarios then random traffic, checked
// against a tree-walk reference model for dirty-aware and pure-PLRU instances.
module tb_victim_sel_plru;

  localparam int WAYS  = 4;
  localparam int SETS  = 4;
  localparam int WW    = $clog2(WAYS);
  localparam int SW    = $clog2(SETS);

  logic            clk = 1'b0;
  logic            rst, en, sel_req, touch_en;
  logic [SW-1:0]   sel_set, touch_set;
  logic [WAYS-1:0] line_valid, line_dirty;
  logic [WW-1:0]   touch_way;
  logic            ack_a, vd_a, ack_p, vd_p;
  logic [WW-1:0]   vic_a, vic_p;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: one bit per tree node, node k has children 2k+1, 2k+2.
  bit tree_m [SETS][WAYS-1];
  int exp_ack, exp_vic_a, exp_vd_a, exp_vic_p, exp_vd_p;

  always #5 clk = ~clk;

  victim_sel_plru #(.NUM_WAYS(WAYS), .NUM_SETS(SETS), .DIRTY_AWARE(1)) u_dut (
    .clk(clk), .rst(rst), .en(en), .sel_req(sel_req), .sel_set(sel_set),
    .line_valid(line_valid), .line_dirty(line_dirty), .touch_en(touch_en),
    .touch_set(touch_set), .touch_way(touch_way),
    .sel_ack(ack_a), .victim(vic_a), .victim_dirty(vd_a)
  );

  victim_sel_plru #(.NUM_WAYS(WAYS), .NUM_SETS(SETS), .DIRTY_AWARE(0)) u_dut_pure (
    .clk(clk), .rst(rst), .en(en), .sel_req(sel_req), .sel_set(sel_set),
    .line_valid(line_valid), .line_dirty(line_dirty), .touch_en(touch_en),
    .touch_set(touch_set), .touch_way(touch_way),
    .sel_ack(ack_p), .victim(vic_p), .victim_dirty(vd_p)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int model_plru(input int s);
    int k = 0;
    int w = 0;
    for (int l = 0; l < WW; l++) begin
      int b = int'(tree_m[s][k]);
      w = w * 2 + b;
      k = 2 * k + 1 + b;
    end
    return w;
  endfunction

  function automatic int model_victim(input int s, input int valid, input int dirty, input bit aware);
    int p = model_plru(s);
    for (int i = 0; i < WAYS; i++)
      if (((valid >> i) & 1) == 0) return i;
    if (aware && ((dirty >> p) & 1) == 1 && dirty != (1 << WAYS) - 1)
      for (int i = 0; i < WAYS; i++)
        if (((dirty >> i) & 1) == 0) return i;
    return p;
  endfunction

  task automatic model_touch(input int s, input int way);
    int k = 0;
    for (int l = 0; l < WW; l++) begin
      int b = (way >> (WW - 1 - l)) & 1;
      tree_m[s][k] = (b == 0);
      k = 2 * k + 1 + b;
    end
  endtask

  // One clock: drive inputs, predict from pre-edge model state, then check.
  task automatic step(input bit r, input bit e, input bit req, input int ss,
                      input int v, input int d, input bit t, input int ts, input int tw);
    rst = r; en = e; sel_req = req; sel_set = SW'(ss);
    line_valid = WAYS'(v); line_dirty = WAYS'(d);
    touch_en = t; touch_set = SW'(ts); touch_way = WW'(tw);
    if (r) begin
      exp_ack = 0; exp_vic_a = 0; exp_vd_a = 0; exp_vic_p = 0; exp_vd_p = 0;
      for (int s = 0; s < SETS; s++)
        for (int k = 0; k < WAYS - 1; k++) tree_m[s][k] = 1'b0;
    end else begin
      exp_ack = (e && req) ? 1 : 0;
      if (e && req) begin
        exp_vic_a = model_victim(ss, v, d, 1'b1);
        exp_vd_a  = (d >> exp_vic_a) & 1;
        exp_vic_p = model_victim(ss, v, d, 1'b0);
        exp_vd_p  = (d >> exp_vic_p) & 1;
      end
      if (e && t) model_touch(ts, tw);
    end
    @(posedge clk);
    #1;
    check("sel_ack",        int'(ack_a), exp_ack);
    check("victim",         int'(vic_a), exp_vic_a);
    check("victim_dirty",   int'(vd_a),  exp_vd_a);
    check("pure_sel_ack",   int'(ack_p), exp_ack);
    check("pure_victim",    int'(vic_p), exp_vic_p);
    check("pure_vic_dirty", int'(vd_p),  exp_vd_p);
    $display("cyc rst=%0b en=%0b req=%0b set=%0d v=%h d=%h touch=%0b/%0d/%0d -> ack=%0b vic=%0d vd=%0b | pure vic=%0d vd=%0b",
             r, e, req, ss, v, d, t, ts, tw, ack_a, vic_a, vd_a, vic_p, vd_p);
  endtask

  task automatic req_only(input int ss, input int v, input int d);
    step(0, 1, 1, ss, v, d, 0, 0, 0);
  endtask

  task automatic touch_only(input int ts, input int tw);
    step(0, 1, 0, 0, 'hF, 0, 1, ts, tw);
  endtask

  initial begin
    rst = 1; en = 0; sel_req = 0; sel_set = '0; line_valid = '0; line_dirty = '0;
    touch_en = 0; touch_set = '0; touch_way = '0;
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 1, 0, 'hF, 0, 1, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Basic PLRU sequencing on set 0, set 1 untouched
    req_only(0, 'hF, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    touch_only(0, 0);
    req_only(0, 'hF, 0);
    touch_only(0, 2);
    req_only(0, 'hF, 0);
    req_only(1, 'hF, 0);

    // Invalid-way priority
    req_only(0, 'hB, 'hF);
    req_only(0, 'h0, 'hF);

    // Dirty-aware preference (state points at way 2)
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    touch_only(0, 0);
    req_only(0, 'hF, 'h4);
    req_only(0, 'hF, 'hF);

    // Same-cycle touch and request on one set reads old state
    step(0, 1, 1, 0, 'hF, 0, 1, 0, 2);
    req_only(0, 'hF, 0);

    // en low freezes state and suppresses requests
    step(0, 0, 1, 0, 'hF, 0, 1, 0, 1);
    req_only(0, 'hF, 0);

    // Reset alongside a request, then back-to-back requests on every set
    touch_only(2, 1);
    touch_only(3, 3);
    step(1, 1, 1, 0, 'hF, 0, 0, 0, 0);
    for (int s = 0; s < SETS; s++) req_only(s, 'hF, 0);
    req_only(0, 'hF, 'h1);
    req_only(1, 'hF, 'h2);
    req_only(2, 'hF, 'h3);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      bit r = ($urandom_range(0, 49) == 0);
      bit e = ($urandom_range(0, 9) != 0);
      int v = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 15)) : 'hF;
      step(r, e, 1'($urandom), int'($urandom_range(0, SETS - 1)), v,
           int'($urandom_range(0, 15)), 1'($urandom),
           int'($urandom_range(0, SETS - 1)), int'($urandom_range(0, WAYS - 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
